// File: rtl/loader_pkg.sv
// rtl/loader_pkg.sv - shared state encoding and word-packing constants for program_loader
package loader_pkg;

    localparam int BYTES_PER_WORD = 4;
    localparam int LANE_W         = $clog2(BYTES_PER_WORD);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_CLEAR,
        ST_LOAD,
        ST_WRITE,
        ST_CHECK,
        ST_RUN,
        ST_ERROR
    } state_t;

endpackage

// File: rtl/word_packer.sv
// rtl/word_packer.sv - lane counter and little-endian assembly of bytes into a 32-bit word
module word_packer
    import loader_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        clear,
    input  logic        byte_strobe,
    input  logic [7:0]  byte_data,
    output logic        word_full,
    output logic [31:0] word
);

    logic [LANE_W-1:0] lane;

    assign word_full = byte_strobe && (lane == LANE_W'(BYTES_PER_WORD - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            lane <= '0;
            word <= '0;
        end else if (clear) begin
            lane <= '0;
            word <= '0;
        end else if (byte_strobe) begin
            lane <= lane + 1'b1;
            // Lane 0 starts a fresh word so stale bytes never leak into the next one.
            if (lane == '0)
                word <= {24'h0, byte_data};
            else
                word <= word | ({24'h0, byte_data} << {lane, 3'b000});
        end
    end

endmodule

// File: rtl/program_loader.sv
// rtl/program_loader.sv - boot loader FSM feeding instruction memory; LOADER_CHECKSUM_EN adds a trailing XOR check byte
module program_loader
    import loader_pkg::*;
#(
    parameter int PC_SIZE        = 10,
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               start,
    input  logic [PC_SIZE-1:0] word_count,
    input  logic               byte_valid,
    input  logic [7:0]         byte_data,
    output logic               byte_ready,
    output logic               imem_clear,
    output logic               imem_we,
    output logic [PC_SIZE-1:0] imem_addr,
    output logic [31:0]        imem_data,
    output logic               core_hold,
    output logic               busy,
    output logic               error
);

    state_t             state, state_nxt;
    logic [PC_SIZE-1:0] wc_q;
    logic [31:0]        tcnt;
    logic               accept, word_full, timeout_hit, start_go;
`ifdef LOADER_CHECKSUM_EN
    logic [7:0]         csum;
`endif

    assign accept      = byte_valid && byte_ready;
    assign timeout_hit = (TIMEOUT_CYCLES != 0) && !accept && (tcnt == 32'(TIMEOUT_CYCLES - 1));
    // CLEAR lasts one cycle and never follows itself, so this marks an accepted start.
    assign start_go    = (state_nxt == ST_CLEAR);

    word_packer u_packer (
        .clk         (clk),
        .rst_n       (rst_n),
        .clear       (start_go),
        .byte_strobe (accept && (state == ST_LOAD)),
        .byte_data   (byte_data),
        .word_full   (word_full),
        .word        (imem_data)
    );

    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE, ST_RUN, ST_ERROR: if (start) state_nxt = ST_CLEAR;
            ST_CLEAR: begin
                if (wc_q != '0)
                    state_nxt = ST_LOAD;
                else
`ifdef LOADER_CHECKSUM_EN
                    state_nxt = ST_CHECK;
`else
                    state_nxt = ST_RUN;
`endif
            end
            ST_LOAD: begin
                if (word_full)        state_nxt = ST_WRITE;
                else if (timeout_hit) state_nxt = ST_ERROR;
            end
            ST_WRITE: begin
                if (imem_addr == wc_q - 1'b1)
`ifdef LOADER_CHECKSUM_EN
                    state_nxt = ST_CHECK;
`else
                    state_nxt = ST_RUN;
`endif
                else
                    state_nxt = ST_LOAD;
            end
`ifdef LOADER_CHECKSUM_EN
            ST_CHECK: begin
                if (accept)           state_nxt = (byte_data == csum) ? ST_RUN : ST_ERROR;
                else if (timeout_hit) state_nxt = ST_ERROR;
            end
`endif
            default: state_nxt = ST_IDLE;
        endcase
    end

    // Outputs are decoded from the next state so they are registered yet aligned with it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= ST_IDLE;
            byte_ready <= 1'b0;
            imem_clear <= 1'b0;
            imem_we    <= 1'b0;
            core_hold  <= 1'b1;
            busy       <= 1'b0;
            error      <= 1'b0;
            imem_addr  <= '0;
            wc_q       <= '0;
            tcnt       <= '0;
`ifdef LOADER_CHECKSUM_EN
            csum       <= '0;
`endif
        end else begin
            state      <= state_nxt;
            byte_ready <= (state_nxt == ST_LOAD) || (state_nxt == ST_CHECK);
            imem_clear <= (state_nxt == ST_CLEAR);
            imem_we    <= (state_nxt == ST_WRITE);
            core_hold  <= (state_nxt != ST_RUN);
            busy       <= (state_nxt == ST_CLEAR) || (state_nxt == ST_LOAD) ||
                          (state_nxt == ST_WRITE) || (state_nxt == ST_CHECK);
            error      <= (state_nxt == ST_ERROR);
            if (start_go) begin
                wc_q      <= word_count;
                imem_addr <= '0;
                tcnt      <= '0;
`ifdef LOADER_CHECKSUM_EN
                csum      <= '0;
`endif
            end else begin
                if (state == ST_WRITE)
                    imem_addr <= imem_addr + 1'b1;
                if ((state == ST_LOAD) || (state == ST_CHECK))
                    tcnt <= accept ? 32'd0 : tcnt + 32'd1;
`ifdef LOADER_CHECKSUM_EN
                if (accept && (state == ST_LOAD))
                    csum <= csum ^ byte_data;
`endif
            end
        end
    end

endmodule
